// File: rtl/bit_ser_pkg.sv
// Shared types and defaults for the bit serializer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bit_ser_pkg;

  localparam int BIT_SER_WIDTH = 8;
  localparam int BIT_SER_DEPTH = 4;

  typedef logic [0:0] state_t;
  localparam state_t S_IDLE  = 1'b0;
  localparam state_t S_SHIFT = 1'b1;

  // One extra wrap bit over the address so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel-in / serial-out bundle between a word source and the serializer.
// Latency: n/a (wires only).
// Backpressure: din_ready qualifies din_valid; the serial side has none.
interface bit_serializer_if
  import bit_ser_pkg::*;
#(
  parameter int WIDTH = BIT_SER_WIDTH
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, word_done, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, word_done, busy
  );
endinterface

// File: rtl/bit_ser_fifo.sv
// Synchronous word FIFO with wrap-bit pointers.
// Latency: a push is visible at rdata/empty on the following cycle.
// Backpressure: pushes while full and pops while empty are ignored.
module bit_ser_fifo
  import bit_ser_pkg::*;
#(
  parameter int WIDTH = BIT_SER_WIDTH,
  parameter int DEPTH = BIT_SER_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bit_serializer.sv
// Buffers parallel words and shifts them out one bit per clock (MSB first; LSB first with BIT_SER_LSB_FIRST_EN).
// Latency: word accepted in cycle T emits its first bit in T+2; queued words follow with no gap.
// Backpressure: din_ready drops while the FIFO is full; the serial output cannot be stalled.
module bit_serializer
  import bit_ser_pkg::*;
#(
  parameter int WIDTH = BIT_SER_WIDTH,
  parameter int DEPTH = BIT_SER_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  bit_serializer_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] rdata;
  logic [CW-1:0]    cnt;
  logic             done_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             load;

  assign push = bus.din_valid && !full;

  // Reload on the last bit of a word keeps consecutive words contiguous.
  assign load = !empty && ((state == S_IDLE) || (cnt == '0));

  bit_ser_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (load),
    .wdata (bus.din),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  // The register drains to zero after a full word, so sout idles low without gating.
`ifdef BIT_SER_LSB_FIRST_EN
  assign shifted  = {1'b0, shreg[WIDTH-1:1]};
  assign bus.sout = shreg[0];
`else
  assign shifted  = {shreg[WIDTH-2:0], 1'b0};
  assign bus.sout = shreg[WIDTH-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      shreg  <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else if (load) begin
      state  <= S_SHIFT;
      shreg  <= rdata;
      cnt    <= CW'(WIDTH - 1);
      done_q <= 1'b0;
    end else if (state == S_SHIFT) begin
      shreg <= shifted;
      if (cnt == '0) begin
        state  <= S_IDLE;
        done_q <= 1'b0;
      end else begin
        cnt    <= cnt - CW'(1);
        done_q <= (cnt == CW'(1));
      end
    end
  end

  assign bus.sout_valid = (state == S_SHIFT);
  assign bus.word_done  = done_q;
  assign bus.din_ready  = !full;
  assign bus.busy       = (state == S_SHIFT) || !empty;

endmodule
